// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the single byte-wide RAM port between instruction
// fetch (IF) and load/store (MEM), serialising word/half/byte accesses into
// little-endian byte transfers.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   if_req/if_addr       fetch request (held until if_done) and address
//   if_data/if_done      fetched word, one-cycle completion pulse
//   mem_req/mem_we       load/store request (held until mem_done), 1=store
//   mem_len/mem_addr     size (0=byte, 1=half, 2/3=word) and address
//   mem_wdata            store data, low N bytes used
//   mem_rdata/mem_done   zero-extended load data, one-cycle completion pulse
//   if_stall/mem_stall   req & ~done, combinational
//   ram_addr/ram_wr      RAM byte address and write enable
//   ram_dout/ram_din     byte to RAM / byte from RAM (one cycle read latency)
//   dbg_state            current FSM state (0=IDLE, 1=READ, 2=WRITE)
//
// Handshake: a request is accepted at the first rising edge seen in IDLE;
// the requester holds req until the matching done pulse and may change its
// address/data freely after acceptance because they are latched then.
module mem_ctrl #(
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req,
    input  logic [31:0]               if_addr,
    output logic [31:0]               if_data,
    output logic                      if_done,
    input  logic                      mem_req,
    input  logic                      mem_we,
    input  logic [1:0]                mem_len,
    input  logic [31:0]               mem_addr,
    input  logic [31:0]               mem_wdata,
    output logic [31:0]               mem_rdata,
    output logic                      mem_done,
    output logic                      if_stall,
    output logic                      mem_stall,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic                      ram_wr,
    output logic [7:0]                ram_dout,
    input  logic [7:0]                ram_din,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state, state_n;

    // step holds k while the next edge is E_k (E0 = acceptance edge)
    logic [2:0]  step, step_n;
    logic [2:0]  nbytes, nbytes_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] wdata_q, wdata_n;
    logic [31:0] rbuf, rbuf_n;
    logic        src_if, src_if_n;

    logic [RAM_ADDR_WIDTH-1:0] ram_addr_n;
    logic                      ram_wr_n;
    logic [7:0]                ram_dout_n;
    logic [31:0]               if_data_n, mem_rdata_n;
    logic                      if_done_n, mem_done_n;

    assign if_stall  = if_req & ~if_done;
    assign mem_stall = mem_req & ~mem_done;
    assign dbg_state = state;

    always_comb begin
        state_n     = state;
        step_n      = step;
        nbytes_n    = nbytes;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        rbuf_n      = rbuf;
        src_if_n    = src_if;
        ram_addr_n  = ram_addr;
        ram_wr_n    = 1'b0;
        ram_dout_n  = ram_dout;
        if_data_n   = if_data;
        mem_rdata_n = mem_rdata;
        if_done_n   = 1'b0;
        mem_done_n  = 1'b0;

        case (state)
            IDLE: begin
                // MEM has priority so loads/stores are not starved by fetch
                if (mem_req) begin
                    addr_n     = mem_addr;
                    wdata_n    = mem_wdata;
                    src_if_n   = 1'b0;
                    step_n     = 3'd1;
                    rbuf_n     = 32'd0;
                    ram_addr_n = RAM_ADDR_WIDTH'(mem_addr);
                    case (mem_len)
                        2'd0:    nbytes_n = 3'd1;
                        2'd1:    nbytes_n = 3'd2;
                        default: nbytes_n = 3'd4;
                    endcase
                    if (mem_we) begin
                        state_n    = WRITE;
                        ram_wr_n   = 1'b1;
                        ram_dout_n = mem_wdata[7:0];
                    end else begin
                        state_n = READ;
                    end
                end else if (if_req) begin
                    addr_n     = if_addr;
                    src_if_n   = 1'b1;
                    step_n     = 3'd1;
                    rbuf_n     = 32'd0;
                    nbytes_n   = 3'd4;
                    ram_addr_n = RAM_ADDR_WIDTH'(if_addr);
                    state_n    = READ;
                end
            end

            READ: begin
                step_n = step + 3'd1;
                if (step < nbytes) begin
                    ram_addr_n = RAM_ADDR_WIDTH'(addr_q + {29'd0, step});
                end
                // byte k-2 arrives on ram_din during the cycle before E_k
                if (step >= 3'd2) begin
                    rbuf_n[{step - 3'd2, 3'b000} +: 8] = ram_din;
                end
                if (step == nbytes + 3'd1) begin
                    state_n = IDLE;
                    if (src_if) begin
                        if_data_n = rbuf_n;
                        if_done_n = 1'b1;
                    end else begin
                        mem_rdata_n = rbuf_n;
                        mem_done_n  = 1'b1;
                    end
                end
            end

            WRITE: begin
                if (step < nbytes) begin
                    ram_wr_n   = 1'b1;
                    ram_addr_n = RAM_ADDR_WIDTH'(addr_q + {29'd0, step});
                    ram_dout_n = wdata_q[{step[1:0], 3'b000} +: 8];
                    step_n     = step + 3'd1;
                end else begin
                    state_n    = IDLE;
                    mem_done_n = 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= 3'd0;
            nbytes    <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rbuf      <= 32'd0;
            src_if    <= 1'b0;
            ram_addr  <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= 8'd0;
            if_data   <= 32'd0;
            mem_rdata <= 32'd0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
        end else begin
            state     <= state_n;
            step      <= step_n;
            nbytes    <= nbytes_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            rbuf      <= rbuf_n;
            src_if    <= src_if_n;
            ram_addr  <= ram_addr_n;
            ram_wr    <= ram_wr_n;
            ram_dout  <= ram_dout_n;
            if_data   <= if_data_n;
            mem_rdata <= mem_rdata_n;
            if_done   <= if_done_n;
            mem_done  <= mem_done_n;
        end
    end

endmodule
